mul8x8_seq_ctrl: RTL and testbench

MUL8X8_SEQ_CTRL -- requirements
Module: mul8x8_seq_ctrl

---
 rtl/mul8x8_seq_ctrl.sv | 105 ++++++++++
 tb/tb_mul8x8_seq_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mul8x8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier built from one shared 4x4 multiplier and a 16-bit accumulator.
// Optional macro MUL_SKIP_LL_EN drops the AL*BL partial product (3-cycle approximate mode).
module mul8x8_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

`ifdef MUL_SKIP_LL_EN
    localparam logic [1:0] FIRST_STEP = 2'd1;
`else
    localparam logic [1:0] FIRST_STEP = 2'd0;
`endif

    state_t      state;
    logic [1:0]  step;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc;

    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [7:0]  prod;
    logic [15:0] partial;

    // step[0] selects the A nibble, step[1] the B nibble: 0:LL 1:HL 2:LH 3:HH
    assign nib_a = step[0] ? a_q[7:4] : a_q[3:0];
    assign nib_b = step[1] ? b_q[7:4] : b_q[3:0];
    assign prod  = {4'h0, nib_a} * {4'h0, nib_b};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        partial = 16'h0000;
        case (step)
            2'd0:    partial = {8'h00, prod};
            2'd1,
            2'd2:    partial = {4'h0, prod, 4'h0};
            default: partial = {prod, 8'h00};
        endcase
    end

    assign p = acc;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            step      <= 2'd0;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            acc       <= 16'h0000;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        acc      <= 16'h0000;
                        step     <= FIRST_STEP;
                        state    <= MUL;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                MUL: begin
                    acc  <= acc + partial;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        step      <= 2'd0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    step      <= 2'd0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul8x8_seq_ctrl.sv
// Directed bench for mul8x8_seq_ctrl: accepted operands feed an expected-product queue
// that is drained and compared on each output handshake.
module tb_mul8x8_seq_ctrl;

`ifdef MUL_SKIP_LL_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int accepts = 0;
    logic [15:0] sb[$];
    int          acc_time[$];

    mul8x8_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] r;
        r = 16'(x) * 16'(y);
`ifdef MUL_SKIP_LL_EN
        r = r - 16'(x[3:0]) * 16'(y[3:0]);
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor on the falling edge: handshakes seen here complete on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b));
                acc_time.push_back(cyc);
                accepts++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(p), 32'hDEAD);
                end else begin
                    check("product", 32'(p), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic step_clk;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [7:0] x, input logic [7:0] y, input int hold);
        int n;
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        out_ready = (hold == 0);
        step_clk();
        in_valid = 1'b0;
        a = ~x;
        b = ~y;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_in_mul", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            step_clk();
            n++;
        end
        check("latency", 32'(n), 32'(LAT));
        for (int i = 0; i < hold; i++) begin
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_p", 32'(p), 32'(model(x, y)));
            step_clk();
        end
        out_ready = 1'b1;
        step_clk();
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = 8'h00;
        b = 8'h00;
        step_clk();
        step_clk();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_p", 32'(p), 32'h0);
        rst = 1'b0;
        step_clk();

        op(8'hFF, 8'hFF, 0);
        op(8'h23, 8'h45, 0);
        op(8'h10, 8'h0A, 5);
        op(8'h00, 8'h5A, 0);

        // Abort an operation at step 2 with an asynchronous reset.
        in_valid = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        step_clk();
        in_valid = 1'b0;
        step_clk();
        step_clk();
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_p", 32'(p), 32'h0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        step_clk();
        rst = 1'b0;
        step_clk();
        op(8'h02, 8'h03, 0);

        // Back-to-back with in_valid held high throughout.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a = 8'h0F;
        b = 8'h0F;
        step_clk();
        a = 8'hF0;
        b = 8'h01;
        n = 0;
        while (accepts < 8 && n < 20) begin
            step_clk();
            n++;
        end
        in_valid = 1'b0;
        check("b2b_second_accept", 32'(accepts), 32'd8);
        n = 0;
        while ((sb.size() != 0 || busy) && n < 30) begin
            step_clk();
            n++;
        end
        check("b2b_spacing", 32'(acc_time[7] - acc_time[6]), 32'(LAT + 2));
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("total_accepts", 32'(accepts), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
